// File: rtl/tl_word_counter.sv
// rtl/tl_word_counter.sv - per-FIFO and aggregate pop-word counters with idle-gated read port
//
// One counter per output FIFO plus an aggregate counter at index NUM_Q.
// A read request is answered only while the datapath is idle; a request
// seen while busy is parked in PENDING until idle rises.
module tl_word_counter #(
  parameter int CNT_W = 5,
  parameter int NUM_Q = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             idle,
  input  logic             req,
  input  logic [2:0]       idx,
  input  logic             pop_in0,
  input  logic             pop_in1,
  input  logic             pop_in2,
  input  logic             pop_in3,
  input  logic             empty_in0,
  input  logic             empty_in1,
  input  logic             empty_in2,
  input  logic             empty_in3,
  output logic [CNT_W-1:0] contador,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_PENDING = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       pend_idx;
  logic [2:0]       sel;
  logic [NUM_Q-1:0] hit;
  logic             clr;

  logic [CNT_W-1:0] cnt     [NUM_Q];
  logic [CNT_W-1:0] cnt_nxt [NUM_Q];
  logic [CNT_W-1:0] cnt_total;
  logic [CNT_W-1:0] total_nxt;
  logic [CNT_W-1:0] add;
  logic [CNT_W-1:0] rd_val;

  // A word leaves FIFO n only when it is popped while not empty.
  assign hit = {pop_in3 & ~empty_in3,
                pop_in2 & ~empty_in2,
                pop_in1 & ~empty_in1,
                pop_in0 & ~empty_in0};

  // Next counter values: held at zero in INIT and on the edge that enters INIT,
  // otherwise incremented by this edge's counted words (modulo 2^CNT_W).
  always_comb begin
    clr = (state == S_INIT) ||
          (init && ((state == S_ACTIVE) || (state == S_PENDING)));
    add = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      cnt_nxt[i] = clr ? '0 : cnt[i] + CNT_W'(hit[i]);
      add        = add + CNT_W'(hit[i]);
    end
    total_nxt = clr ? '0 : cnt_total + add;
  end

  // Read mux works on the next values so a pop on the answering edge is included;
  // out-of-range indices read as zero.
  always_comb begin
    sel    = (state == S_PENDING) ? pend_idx : idx;
    rd_val = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (int'(sel) == i) rd_val = cnt_nxt[i];
    end
    if (int'(sel) == NUM_Q) rd_val = total_nxt;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_Q; i++) cnt[i] <= '0;
      cnt_total <= '0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) cnt[i] <= cnt_nxt[i];
      cnt_total <= total_nxt;
    end
  end

  // Read-port FSM with registered contador/valid/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      pend_idx <= '0;
      contador <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_INIT: begin
          busy <= 1'b0;
          if (!init) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (init) begin
            state <= S_INIT;
          end else if (req) begin
            pend_idx <= idx;
            if (idle) begin
              state    <= S_RESP;
              valid    <= 1'b1;
              contador <= rd_val;
            end else begin
              state <= S_PENDING;
              busy  <= 1'b1;
            end
          end
        end
        S_PENDING: begin
          if (init) begin
            state <= S_INIT;
            busy  <= 1'b0;
          end else if (idle) begin
            state    <= S_RESP;
            valid    <= 1'b1;
            busy     <= 1'b0;
            contador <= rd_val;
          end
        end
        S_RESP: begin
          // Requests seen here are not taken; the requester retries from ACTIVE.
          state <= S_ACTIVE;
        end
        default: begin
          state <= S_INIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
